// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: sequential DIMxDIM matrix multiplier, one result element per cycle over valid/ready buses.
// Define MATMUL_SEQ_ACCUM_EN to add each product onto the previous result (running sum, cleared only by reset).
module matrix_mult_seq #(
  parameter int DIM   = 4,
  parameter int DW    = 16,
  parameter int BUS_W = DIM*DIM*DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             busy
);
  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [RW-1:0] LAST = RW'(DIM-1);
  typedef enum logic [1:0] {WAIT_A, WAIT_B, COMPUTE, DONE} state_t;
  state_t state_q, state_d;
  logic [BUS_W-1:0] a_q, b_q;
  logic [DW-1:0] a_m [DIM][DIM];
  logic [DW-1:0] b_m [DIM][DIM];
  logic [DW-1:0] res_q [DIM][DIM];
  logic [RW-1:0] row_q, col_q;
  logic [DW-1:0] dot, elem;
  logic in_fire, last;
  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      assign a_m[i][j] = a_q[(i*DIM+j)*DW +: DW];
      assign b_m[i][j] = b_q[(i*DIM+j)*DW +: DW];
      assign out_data[(i*DIM+j)*DW +: DW] = res_q[i][j];
    end
  end
  assign in_fire = in_valid && in_ready;
  assign last = (row_q == LAST) && (col_q == LAST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= WAIT_A;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_A:  state_d = in_fire ? WAIT_B : WAIT_A;
      WAIT_B:  state_d = in_fire ? COMPUTE : WAIT_B;
      COMPUTE: state_d = last ? DONE : COMPUTE;
      DONE:    state_d = out_ready ? WAIT_A : DONE;
      default: state_d = WAIT_A;
    endcase
  end
  always_comb begin
    in_ready  = (state_q == WAIT_A) || (state_q == WAIT_B);
    out_valid = state_q == DONE;
    busy      = state_q != WAIT_A;
  end
  // Products and the sum wrap at DW bits, so truncating each term is exact.
  always_comb begin
    dot = '0;
    for (int m = 0; m < DIM; m++) dot = dot + a_m[row_q][m] * b_m[m][col_q];
  end
`ifdef MATMUL_SEQ_ACCUM_EN
  assign elem = res_q[row_q][col_q] + dot;
`else
  assign elem = dot;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      row_q <= '0;
      col_q <= '0;
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) res_q[i][j] <= '0;
    end else begin
      if (state_q == WAIT_A && in_fire) a_q <= in_data;
      if (state_q == WAIT_B && in_fire) begin
        b_q   <= in_data;
        row_q <= '0;
        col_q <= '0;
      end
      if (state_q == COMPUTE) begin
        res_q[row_q][col_q] <= elem;
        col_q <= (col_q == LAST) ? '0 : col_q + 1'b1;
        row_q <= last ? '0 : (col_q == LAST) ? row_q + 1'b1 : row_q;
      end
    end
endmodule

// File: doc/matrix_mult_seq.md
Name: matrix_mult_seq

Overview:
- Clocked, parametrised successor to the unclocked 4x4 matrix multiplier: DIM x DIM matrices of DW-bit elements.
- Accepts operand A, then operand B, on one flat valid/ready input bus; returns C = A*B on a valid/ready output bus.
- Computes one result element per cycle using a DIM-wide dot-product datapath.
- Sits between the matrix-engine input bus and the result bus, replacing combinational re-evaluation with a deterministic handshake.

Parameters:
- DIM, 4, matrix dimension (rows = cols); legal 2..8.
- DW, 16, element width in bits (unsigned).
- BUS_W, DIM*DIM*DW, derived flat bus width; not to be overridden.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a matrix.
- in_ready  out  1  block can accept a matrix this cycle.
- in_data  in  BUS_W  element (i,j) at bits [(i*DIM+j)*DW +: DW], row-major, row 0 in LSBs.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  BUS_W  result C, same packing as in_data.
- busy  out  1  high in any state other than WAIT_A.

Behaviour:
- Reset (async assert, sync release):
  - state = WAIT_A; in_ready = 1; out_valid = 0; busy = 0.
  - out_data, A and B registers, and element counter cleared to 0.
- Handshake: transfer occurs on a rising edge with valid & ready both high. in_valid with in_ready low is ignored, with no side effects.
- WAIT_A:
  - in_ready = 1.
  - On transfer, latch A and go to WAIT_B.
- WAIT_B:
  - in_ready = 1.
  - On transfer, latch B, counter = 0, go to COMPUTE.
- COMPUTE:
  - in_ready = 0; busy = 1.
  - Each cycle k = 0..DIM*DIM-1: r = k / DIM, c = k % DIM.
  - Write C[r][c] = sum over m of A[r][m]*B[m][c], computed modulo 2^DW: products and sum truncated to DW bits.
  - After the write at k = DIM*DIM-1, go to DONE.
- DONE:
  - out_valid = 1; out_data stable while out_valid=1 and out_ready=0.
  - On out_ready, next cycle: out_valid = 0, state = WAIT_A, in_ready = 1.
- Latency: out_valid rises exactly DIM*DIM clock edges after the edge that accepts B (16 for DIM=4). Fixed and data-independent.
- No overlap: next A cannot be accepted until the result is consumed (in_ready = 0 in COMPUTE and DONE).
- out_ready while out_valid=0: ignored.
- out_data between results: holds the last result; only meaningful while out_valid=1.
- Reset mid-COMPUTE or mid-DONE: operation aborted, result discarded, all outputs at reset values immediately (async).
- Any in_valid/in_data change outside a transfer: no effect (unlike the previous generation, which recomputed on every bus change).

Optional Feature:
- Macro MATMUL_SEQ_ACCUM_EN.
- Defined:
  - Result registers are not cleared per operation; each COMPUTE writes C[r][c] = C_prev[r][c] + dot(A row r, B col c), modulo 2^DW.
  - C_prev cleared only by reset. Gives a running sum of products across operations.
- Undefined:
  - C[r][c] = dot(...) only; prior contents overwritten.
  - No accumulator-hold logic synthesised.

Test Plan:
- DIM=4: A = identity (diag 0x0001), B with B[i][j] = i*4+j -> out_data equals B; out_valid high exactly 16 edges after B accepted.
- A all 0x0002, B all 0x0003 -> every C element 0x0018.
- Overflow: A = B = diag 0x0100 -> diag products 0x10000 truncate to 0x0000; all C elements 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid:
  - out_valid and out_data stable throughout; in_ready stays 0; in_valid pulses in that window ignored.
  - Raise out_ready -> in_ready=1 on the next cycle.
- Reset: assert rst_n=0 at compute cycle 7 -> out_valid=0, in_ready=1 immediately. Next A=B=identity -> result identity.
- With MATMUL_SEQ_ACCUM_EN: two consecutive identity*identity operations -> second result diag 0x0002, off-diagonal 0. Without the macro, the second result is diag 0x0001.
